// File: rtl/data_bus_arbiter_if.sv
// Bundles the two requester ports and the data-RAM port of the data bus arbiter.
// slave modport is the arbiter's view; master modport is the system/bench view.
// Widths are taken from the instance parameters and must match the arbiter's.
interface data_bus_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  // Port 0: micro register-file data path
  logic              i_Req0;
  logic              i_We0;
  logic [ADDR_W-1:0] i_Addr0;
  logic [DATA_W-1:0] i_Wdata0;
  logic              o_Gnt0;
  logic              o_Ack0;
  // Port 1: loader / debug master
  logic              i_Req1;
  logic              i_We1;
  logic [ADDR_W-1:0] i_Addr1;
  logic [DATA_W-1:0] i_Wdata1;
  logic              o_Gnt1;
  logic              o_Ack1;
  // Shared read data and memory side
  logic [DATA_W-1:0] o_Rdata;
  logic              o_Mem_En;
  logic              o_Mem_We;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [DATA_W-1:0] o_Mem_Wdata;
  logic [DATA_W-1:0] i_Mem_Rdata;
  logic              o_Busy;

  modport slave (
    input  i_Req0, i_We0, i_Addr0, i_Wdata0,
    input  i_Req1, i_We1, i_Addr1, i_Wdata1,
    input  i_Mem_Rdata,
    output o_Gnt0, o_Ack0, o_Gnt1, o_Ack1, o_Rdata,
    output o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Busy
  );

  modport master (
    output i_Req0, i_We0, i_Addr0, i_Wdata0,
    output i_Req1, i_We1, i_Addr1, i_Wdata1,
    output i_Mem_Rdata,
    input  o_Gnt0, o_Ack0, o_Gnt1, o_Ack1, o_Rdata,
    input  o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Busy
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous data RAM, with a burst limit per tenure.
// Grant 1 cycle after request from IDLE; ack (with read data) 1 cycle after each transfer.
// A requester waits (request held) until it owns the bus; a lone owner is never pre-empted.
module data_bus_arbiter #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic               i_Clk,
  input logic               i_Rst,
  data_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       rr_last_q;   // port most recently granted; the other one wins a tie
  logic       ack0_q;
  logic       ack1_q;
  logic       xfer0;
  logic       xfer1;
  logic       burst_done;

  // A transfer happens whenever the owner keeps its request up
  assign xfer0 = (state_q == OWN0) && bus.i_Req0;
  assign xfer1 = (state_q == OWN1) && bus.i_Req1;

  // Transfers in the current tenure including this cycle, saturating at the burst limit
  always_comb begin
    cnt_d = cnt_q;
    if ((xfer0 || xfer1) && (cnt_q < MAX_B)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign burst_done = (cnt_d >= MAX_B);

  // Memory port follows the owner combinationally; idle cycles drive all zeros
  always_comb begin
    bus.o_Mem_En    = 1'b0;
    bus.o_Mem_We    = 1'b0;
    bus.o_Mem_Addr  = '0;
    bus.o_Mem_Wdata = '0;
    if (xfer0) begin
      bus.o_Mem_En    = 1'b1;
      bus.o_Mem_We    = bus.i_We0;
      bus.o_Mem_Addr  = bus.i_Addr0;
      bus.o_Mem_Wdata = bus.i_Wdata0;
    end else if (xfer1) begin
      bus.o_Mem_En    = 1'b1;
      bus.o_Mem_We    = bus.i_We1;
      bus.o_Mem_Addr  = bus.i_Addr1;
      bus.o_Mem_Wdata = bus.i_Wdata1;
    end
  end

  assign bus.o_Gnt0  = (state_q == OWN0);
  assign bus.o_Gnt1  = (state_q == OWN1);
  assign bus.o_Busy  = (state_q != IDLE);
  assign bus.o_Ack0  = ack0_q;
  assign bus.o_Ack1  = ack1_q;
  // RAM output is only meaningful in the cycle after an access, so gate it by the acks
  assign bus.o_Rdata = (ack0_q || ack1_q) ? bus.i_Mem_Rdata : '0;

  // Ownership FSM plus the ack pipeline; acks follow transfers even across an ownership change
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      ack0_q <= xfer0;
      ack1_q <= xfer1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.i_Req0 && bus.i_Req1) begin
            if (rr_last_q) begin
              state_q   <= OWN0;
              rr_last_q <= 1'b0;
            end else begin
              state_q   <= OWN1;
              rr_last_q <= 1'b1;
            end
          end else if (bus.i_Req0) begin
            state_q   <= OWN0;
            rr_last_q <= 1'b0;
          end else if (bus.i_Req1) begin
            state_q   <= OWN1;
            rr_last_q <= 1'b1;
          end
        end
        OWN0: begin
          if (bus.i_Req1 && (!bus.i_Req0 || burst_done)) begin
            state_q   <= OWN1;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
          end else if (!bus.i_Req0 && !bus.i_Req1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        OWN1: begin
          if (bus.i_Req0 && (!bus.i_Req1 || burst_done)) begin
            state_q   <= OWN0;
            rr_last_q <= 1'b0;
            cnt_q     <= '0;
          end else if (!bus.i_Req0 && !bus.i_Req1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
